// File: rtl/code_preimage_finder_if.sv
// Handshake and result bundle for code_preimage_finder: a start/codeword request in,
// and busy/done status plus the registered preimage results out.
interface code_preimage_finder_if;
  logic       i_start;
  logic [3:0] i_in;
  logic       o_busy;
  logic       o_done;
  logic       o_found;
  logic [2:0] o_out;
  logic [7:0] o_mask;
  logic [3:0] o_count;

  modport master (
    output i_start, i_in,
    input  o_busy, o_done, o_found, o_out, o_mask, o_count
  );

  modport slave (
    input  i_start, i_in,
    output o_busy, o_done, o_found, o_out, o_mask, o_count
  );
endinterface

// File: rtl/code_preimage_finder.sv
// Sequential inverse of the 3-bit -> 4-bit lab code map: scans k = 0..7 one per clock
// and reports the lowest preimage, the full preimage mask and the preimage count.
module code_preimage_finder #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  code_preimage_finder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_k, w_k_nxt;
  logic [3:0] r_code, w_code_nxt;
  logic       r_found, w_found_nxt;
  logic [2:0] r_out, w_out_nxt;
  logic [7:0] r_mask, w_mask_nxt;
  logic [3:0] r_count, w_count_nxt;
  logic       r_busy;
  logic       r_done;

  logic [3:0] w_f;
  logic       w_match;

  // Forward map f(k) = 1,9,7,6,0,3,1,9 as sum-of-products on the scan index.
  assign w_f[3]  = r_k[0] & ~(r_k[2] ^ r_k[1]);
  assign w_f[2]  = ~r_k[2] & r_k[1];
  assign w_f[1]  = (~r_k[2] & r_k[1]) | (r_k[2] & ~r_k[1] & r_k[0]);
  assign w_f[0]  = ~(~r_k[2] & r_k[1] & r_k[0]) & ~(r_k[2] & ~r_k[1] & ~r_k[0]);
  assign w_match = (w_f == r_code);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_code_nxt  = r_code;
    w_found_nxt = r_found;
    w_out_nxt   = r_out;
    w_mask_nxt  = r_mask;
    w_count_nxt = r_count;

    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_state_nxt = S_SCAN;
          w_code_nxt  = bus.i_in;
          w_k_nxt     = 3'd0;
          w_found_nxt = 1'b0;
          w_out_nxt   = 3'd0;
          w_mask_nxt  = 8'h00;
          w_count_nxt = 4'd0;
        end
      end

      S_SCAN: begin
        if (w_match) begin
          w_mask_nxt[r_k] = 1'b1;
          w_count_nxt     = r_count + 4'd1;
          // Ascending scan: the first hit is the minimum preimage.
          if (!r_found) begin
            w_found_nxt = 1'b1;
            w_out_nxt   = r_k;
          end
        end
        if (r_k == 3'd7 || (EARLY_EXIT && w_match)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_k_nxt = r_k + 3'd1;
        end
      end

      S_DONE: w_state_nxt = S_IDLE;

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= 3'd0;
      r_code  <= 4'd0;
      r_found <= 1'b0;
      r_out   <= 3'd0;
      r_mask  <= 8'h00;
      r_count <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_code  <= w_code_nxt;
      r_found <= w_found_nxt;
      r_out   <= w_out_nxt;
      r_mask  <= w_mask_nxt;
      r_count <= w_count_nxt;
      // Status flags are decoded from the next state so they stay registered outputs.
      r_busy  <= (w_state_nxt == S_SCAN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;
  assign bus.o_found = r_found;
  assign bus.o_out   = r_out;
  assign bus.o_mask  = r_mask;
  assign bus.o_count = r_count;

  a_busy_done_exclusive : assert property (@(posedge clk) disable iff (rst) !(r_busy && r_done));
  a_done_single_cycle   : assert property (@(posedge clk) disable iff (rst) r_done |=> !r_done);

endmodule

// File: tb/tb_code_preimage_finder.sv
// Scoreboard bench for code_preimage_finder: one instance per EARLY_EXIT setting,
// expected results queued at launch and compared when each done pulse appears.
module tb_code_preimage_finder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  code_preimage_finder_if bus0 ();
  code_preimage_finder_if bus1 ();

  code_preimage_finder #(.EARLY_EXIT(1'b0)) u_dut_full (.clk(clk), .rst(rst), .bus(bus0));
  code_preimage_finder #(.EARLY_EXIT(1'b1)) u_dut_early (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    int         done_cyc;
    logic       found;
    logic [2:0] out;
    logic [7:0] mask;
    logic [3:0] count;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic prev_done [2] = '{1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [3:0] f_ref(input int k);
    case (k)
      0: return 4'd1;
      1: return 4'd9;
      2: return 4'd7;
      3: return 4'd6;
      4: return 4'd0;
      5: return 4'd3;
      6: return 4'd1;
      default: return 4'd9;
    endcase
  endfunction

  // Reference result and done cycle for a scan accepted at the edge that set cyc = a.
  function automatic exp_t model(input logic [3:0] code, input bit ee, input int a);
    exp_t e;
    int   last;
    e.found = 1'b0; e.out = 3'd0; e.mask = 8'h00; e.count = 4'd0;
    last = 7;
    for (int k = 0; k < 8; k++) begin
      if (f_ref(k) == code) begin
        e.mask[k] = 1'b1;
        e.count   = e.count + 4'd1;
        if (!e.found) begin
          e.found = 1'b1;
          e.out   = 3'(k);
        end
        if (ee) begin
          last = k;
          break;
        end
      end
    end
    e.done_cyc = a + last + 1;
    return e;
  endfunction

  task automatic score(input int which, input logic busy, input logic done, input logic found,
                       input logic [2:0] out, input logic [7:0] mask, input logic [3:0] count);
    exp_t  e;
    string p;
    p = (which == 0) ? "full" : "early";
    if (done) begin
      check({p, "_busy_during_done"}, 32'(busy), 32'd0);
      check({p, "_done_back_to_back"}, 32'(prev_done[which]), 32'd0);
      if ((which == 0 ? q0.size() : q1.size()) == 0) begin
        check({p, "_spurious_done"}, 32'd1, 32'd0);
      end else begin
        e = (which == 0) ? q0.pop_front() : q1.pop_front();
        check({p, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
        check({p, "_found"}, 32'(found), 32'(e.found));
        check({p, "_out"}, 32'(out), 32'(e.out));
        check({p, "_mask"}, 32'(mask), 32'(e.mask));
        check({p, "_count"}, 32'(count), 32'(e.count));
      end
    end
    prev_done[which] = done;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      score(0, bus0.o_busy, bus0.o_done, bus0.o_found, bus0.o_out, bus0.o_mask, bus0.o_count);
      score(1, bus1.o_busy, bus1.o_done, bus1.o_found, bus1.o_out, bus1.o_mask, bus1.o_count);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_full_outputs"},
          {18'd0, bus0.o_busy, bus0.o_done, bus0.o_found, bus0.o_out, bus0.o_mask, bus0.o_count},
          32'd0);
    check({tag, "_early_outputs"},
          {18'd0, bus1.o_busy, bus1.o_done, bus1.o_found, bus1.o_out, bus1.o_mask, bus1.o_count},
          32'd0);
  endtask

  // Drives start for one cycle into an idle DUT; a returns the accept-edge cycle stamp.
  task automatic launch(input int which, input logic [3:0] c, input bit push, output int a);
    @(negedge clk);
    if (which == 0) begin bus0.i_start = 1'b1; bus0.i_in = c; end
    else            begin bus1.i_start = 1'b1; bus1.i_in = c; end
    @(posedge clk);
    #1;
    a = cyc;
    if (push) begin
      if (which == 0) q0.push_back(model(c, 1'b0, a));
      else            q1.push_back(model(c, 1'b1, a));
    end
    if (which == 0) bus0.i_start = 1'b0;
    else            bus1.i_start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    bus0.i_start = 1'b0; bus0.i_in = 4'd0;
    bus1.i_start = 1'b0; bus1.i_in = 4'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;

    // in = 9, full scan, with busy window checked cycle by cycle.
    launch(0, 4'd9, 1'b1, a);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("busy_in_scan", 32'(bus0.o_busy), 32'd1);
    end
    @(negedge clk);
    check("busy_in_done", 32'(bus0.o_busy), 32'd0);
    wait_drain(40);

    launch(0, 4'd4, 1'b1, a);
    wait_drain(40);

    launch(1, 4'd1, 1'b1, a);
    wait_drain(40);
    launch(0, 4'd1, 1'b1, a);
    wait_drain(40);
    launch(1, 4'd9, 1'b1, a);
    wait_drain(40);
    launch(1, 4'd4, 1'b1, a);
    wait_drain(40);

    // in = 7 with start re-pulsed and in changed mid-scan: exactly one done, code_q used.
    launch(0, 4'd7, 1'b1, a);
    @(negedge clk);
    bus0.i_start = 1'b1; bus0.i_in = 4'd0;
    repeat (3) @(negedge clk);
    bus0.i_start = 1'b0;
    wait_drain(40);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("results_hold_out", 32'(bus0.o_out), 32'd2);
    check("results_hold_mask", 32'(bus0.o_mask), 32'h04);

    // in = 3 aborted by reset mid-scan: results cleared, no done.
    launch(0, 4'd3, 1'b0, a);
    @(negedge clk);
    check("clear_on_accept_mask", 32'(bus0.o_mask), 32'h00);
    check("clear_on_accept_busy", 32'(bus0.o_busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("after_midscan_reset");
    repeat (14) @(posedge clk);
    launch(0, 4'd6, 1'b1, a);
    wait_drain(40);

    // Held start sweeping every codeword: accepts every 10 cycles.
    @(negedge clk);
    bus0.i_start = 1'b1; bus0.i_in = 4'd0;
    @(posedge clk);
    #1;
    a = cyc;
    q0.push_back(model(4'd0, 1'b0, a));
    for (int c = 1; c < 16; c++) begin
      bus0.i_in = 4'(c);
      repeat (10) @(posedge clk);
      #1;
      a = a + 10;
      q0.push_back(model(4'(c), 1'b0, a));
    end
    @(negedge clk);
    bus0.i_start = 1'b0;
    wait_drain(60);
    repeat (12) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
